// File: rtl/tt_um_raybello_tt_pure_sine_gen.sv
// Direct digital synthesis sine generator: 16-bit phase accumulator driving a quarter-wave ROM.
// Latency: one clock from accumulator to uo_out. There is no backpressure; ena=0 or HOLD freezes the phase.
module tt_um_raybello_tt_pure_sine_gen (
  input  logic [7:0] ui_in,
  output logic [7:0] uo_out,
  input  logic [7:0] uio_in,
  output logic [7:0] uio_out,
  output logic [7:0] uio_oe,
  input  logic       ena,
  input  logic       clk,
  input  logic       rst_n
);

  logic [15:0] acc;
  logic [16:0] acc_sum;
  logic [7:0]  phase;
  logic [5:0]  idx;
  logic [6:0]  q;
  logic [7:0]  q_ext;
  logic [7:0]  mag;
  logic signed [7:0] scaled;
  logic [7:0]  next_sample;
  logic [7:0]  sample;
  logic        sq;
  logic        wrap;
  logic [1:0]  sh;
  logic        hold;
  logic        fmt;
  logic        unused_uio;

  assign sh         = uio_in[1:0];
  assign hold       = uio_in[2];
  assign fmt        = uio_in[3];
  assign unused_uio = &{1'b0, uio_in[7:4]};

  assign acc_sum = {1'b0, acc} + {9'd0, ui_in};
  assign phase   = acc[15:8];
  // Odd quadrants walk the table backwards; 63-I is the bitwise complement of I.
  assign idx     = phase[6] ? ~phase[5:0] : phase[5:0];

  always_comb begin
    q = 7'd0;
    case (idx)
      6'd0:  q = 7'd2;   6'd1:  q = 7'd5;   6'd2:  q = 7'd8;   6'd3:  q = 7'd11;
      6'd4:  q = 7'd14;  6'd5:  q = 7'd17;  6'd6:  q = 7'd20;  6'd7:  q = 7'd23;
      6'd8:  q = 7'd26;  6'd9:  q = 7'd29;  6'd10: q = 7'd32;  6'd11: q = 7'd35;
      6'd12: q = 7'd38;  6'd13: q = 7'd41;  6'd14: q = 7'd44;  6'd15: q = 7'd47;
      6'd16: q = 7'd50;  6'd17: q = 7'd53;  6'd18: q = 7'd56;  6'd19: q = 7'd58;
      6'd20: q = 7'd61;  6'd21: q = 7'd64;  6'd22: q = 7'd67;  6'd23: q = 7'd69;
      6'd24: q = 7'd72;  6'd25: q = 7'd74;  6'd26: q = 7'd77;  6'd27: q = 7'd79;
      6'd28: q = 7'd82;  6'd29: q = 7'd84;  6'd30: q = 7'd86;  6'd31: q = 7'd89;
      6'd32: q = 7'd91;  6'd33: q = 7'd93;  6'd34: q = 7'd95;  6'd35: q = 7'd97;
      6'd36: q = 7'd99;  6'd37: q = 7'd101; 6'd38: q = 7'd103; 6'd39: q = 7'd105;
      6'd40: q = 7'd106; 6'd41: q = 7'd108; 6'd42: q = 7'd110; 6'd43: q = 7'd111;
      6'd44: q = 7'd113; 6'd45: q = 7'd114; 6'd46: q = 7'd115; 6'd47: q = 7'd117;
      6'd48: q = 7'd118; 6'd49: q = 7'd119; 6'd50: q = 7'd120; 6'd51: q = 7'd121;
      6'd52: q = 7'd122; 6'd53: q = 7'd123; 6'd54: q = 7'd124; 6'd55: q = 7'd124;
      6'd56: q = 7'd125; 6'd57: q = 7'd125; 6'd58: q = 7'd126; 6'd59: q = 7'd126;
      default: q = 7'd127;
    endcase
  end

  assign q_ext  = {1'b0, q};
  assign mag    = phase[7] ? (~q_ext + 8'd1) : q_ext;
  assign scaled = $signed(mag) >>> sh;
  // Offset-binary is two's complement with the sign bit inverted.
  assign next_sample = fmt ? scaled : {~scaled[7], scaled[6:0]};

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc    <= 16'd0;
      sample <= 8'h80;
      sq     <= 1'b0;
      wrap   <= 1'b0;
    end else if (ena) begin
      if (!hold) acc <= acc_sum[15:0];
      wrap   <= !hold && acc_sum[16];
      sample <= next_sample;
      sq     <= acc[15];
    end
  end

  assign uo_out  = sample;
  assign uio_out = {sq, wrap, 6'b000000};
  assign uio_oe  = 8'hF0;

endmodule

// File: tb/tb_tt_um_raybello_tt_pure_sine_gen.sv
// Directed bench for the sine generator: table of full-period sweeps plus reset, zero-frequency and freeze sequences.
module tb_tt_um_raybello_tt_pure_sine_gen;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ena = 1'b0;
  logic [7:0] ui_in = 8'd0;
  logic [7:0] uio_in = 8'd0;
  logic [7:0] uo_out;
  logic [7:0] uio_out;
  logic [7:0] uio_oe;

  int n_checks = 0;
  int n_fail = 0;

  typedef struct {
    logic [7:0] ftw;
    logic [1:0] sh;
    logic       fmt;
    int         exp_first;
    int         exp_max;
    int         exp_min;
  } vec_t;

  vec_t vecs[6];

  tt_um_raybello_tt_pure_sine_gen dut (
    .ui_in  (ui_in),
    .uo_out (uo_out),
    .uio_in (uio_in),
    .uio_out(uio_out),
    .uio_oe (uio_oe),
    .ena    (ena),
    .clk    (clk),
    .rst_n  (rst_n)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic set_ctrl(input logic [7:0] ftw, input logic [1:0] sh, input logic hold, input logic fmt);
    ui_in  = ftw;
    uio_in = {4'b1010, fmt, hold, sh};
  endtask

  // Reset with deliberately hostile inputs, then load the run controls and release.
  task automatic do_reset(input logic [7:0] ftw, input logic [1:0] sh, input logic fmt);
    rst_n = 1'b0;
    ena   = 1'b1;
    set_ctrl(8'hFF, 2'd3, 1'b1, 1'b1);
    tick();
    tick();
    check("reset uo_out", uo_out, 8'h80);
    check("reset uio_out", uio_out, 8'h00);
    check("reset uio_oe", uio_oe, 8'hF0);
    set_ctrl(ftw, sh, 1'b0, fmt);
    rst_n = 1'b1;
  endtask

  int vmax, vmin, v, sq_high, n_wrap, first_wrap, last_wrap, bad_intv, period, bad;
  int early[5];

  initial begin
    vecs[0] = '{ftw: 8'd128, sh: 2'd0, fmt: 1'b0, exp_first: 8'h82, exp_max: 255, exp_min: 1};
    vecs[1] = '{ftw: 8'd128, sh: 2'd1, fmt: 1'b0, exp_first: 8'h81, exp_max: 191, exp_min: 64};
    vecs[2] = '{ftw: 8'd128, sh: 2'd2, fmt: 1'b0, exp_first: 8'h80, exp_max: 159, exp_min: 96};
    vecs[3] = '{ftw: 8'd128, sh: 2'd3, fmt: 1'b0, exp_first: 8'h80, exp_max: 143, exp_min: 112};
    vecs[4] = '{ftw: 8'd128, sh: 2'd0, fmt: 1'b1, exp_first: 8'h02, exp_max: 127, exp_min: -127};
    vecs[5] = '{ftw: 8'd256 - 8'd1 + 8'd1, sh: 2'd0, fmt: 1'b0, exp_first: 8'h82, exp_max: 255, exp_min: 1};
    vecs[5].ftw = 8'd0;
    vecs[5].ftw[7] = 1'b1;
    vecs[5].ftw = 8'd64;

    // Zero frequency: the phase never moves, so the sample stays at Q[0].
    do_reset(8'd0, 2'd0, 1'b0);
    bad = 0;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (uo_out !== 8'h82 || uio_out[6] !== 1'b0) bad++;
    end
    check("ftw0 samples not constant 0x82 or wrap seen", bad, 0);

    // First few samples of a FTW=128 run: phase advances one step every two clocks.
    early = '{8'h82, 8'h82, 8'h85, 8'h85, 8'h88};
    do_reset(8'd128, 2'd0, 1'b0);
    for (int k = 0; k < 5; k++) begin
      tick();
      check($sformatf("early sample %0d", k + 1), uo_out, early[k]);
    end

    for (int r = 0; r < 6; r++) begin
      do_reset(vecs[r].ftw, vecs[r].sh, vecs[r].fmt);
      period = 65536 / int'(vecs[r].ftw);
      vmax = -1000; vmin = 1000; sq_high = 0; n_wrap = 0;
      first_wrap = -1; last_wrap = -1; bad_intv = 0;
      for (int k = 1; k <= 1100; k++) begin
        tick();
        v = vecs[r].fmt ? int'($signed(uo_out)) : int'(uo_out);
        if (k == 1) check($sformatf("vec%0d first sample", r), v, vecs[r].fmt ? int'($signed(vecs[r].exp_first[7:0])) : vecs[r].exp_first);
        if (v > vmax) vmax = v;
        if (v < vmin) vmin = v;
        if (k <= period && uio_out[7]) sq_high++;
        if (uio_out[6]) begin
          n_wrap++;
          if (first_wrap < 0) first_wrap = k;
          else if (k - last_wrap != period) bad_intv++;
          last_wrap = k;
        end
      end
      check($sformatf("vec%0d max", r), vmax, vecs[r].exp_max);
      check($sformatf("vec%0d min", r), vmin, vecs[r].exp_min);
      check($sformatf("vec%0d first wrap", r), first_wrap, period);
      check($sformatf("vec%0d wrap count", r), n_wrap, 1100 / period);
      check($sformatf("vec%0d wrap spacing errors", r), bad_intv, 0);
      check($sformatf("vec%0d sq high clocks", r), sq_high, period / 2);
    end

    // Freeze: after 300 edges ACC=38400 (P=150, -Q[22]=-67 -> 0x3D).
    do_reset(8'd128, 2'd0, 1'b0);
    for (int k = 0; k < 300; k++) tick();
    set_ctrl(8'd128, 2'd0, 1'b1, 1'b0);
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (uo_out !== 8'h3D || uio_out[7] !== 1'b1 || uio_out[6] !== 1'b0) bad++;
    end
    check("hold frozen sample errors", bad, 0);
    set_ctrl(8'd128, 2'd1, 1'b1, 1'b0);
    tick();
    check("hold sh=1 on frozen phase", uo_out, 8'h5E);
    set_ctrl(8'd128, 2'd1, 1'b1, 1'b1);
    tick();
    check("hold fmt=1 on frozen phase", uo_out, 8'hDE);
    set_ctrl(8'd128, 2'd0, 1'b1, 1'b0);
    tick();
    check("hold restored format", uo_out, 8'h3D);
    set_ctrl(8'd128, 2'd0, 1'b0, 1'b0);
    tick();
    check("hold release edge 1", uo_out, 8'h3D);
    tick();
    check("hold release edge 2", uo_out, 8'h3D);
    tick();
    check("hold release edge 3", uo_out, 8'h3B);

    // ena=0 freezes everything, including the registered sample.
    ena = 1'b0;
    bad = 0;
    for (int k = 0; k < 50; k++) begin
      tick();
      if (uo_out !== 8'h3B || uio_out !== 8'h80) bad++;
    end
    check("ena low frozen errors", bad, 0);
    ena = 1'b1;
    tick();
    check("ena release edge 1", uo_out, 8'h3B);
    tick();
    check("ena release edge 2", uo_out, 8'h38);

    // Reset mid-period wins even with ena low, and the phase restarts at zero.
    ena   = 1'b0;
    rst_n = 1'b0;
    tick();
    check("mid reset uo_out", uo_out, 8'h80);
    check("mid reset uio_out", uio_out, 8'h00);
    rst_n = 1'b1;
    ena   = 1'b1;
    tick();
    check("post reset first sample", uo_out, 8'h82);
    tick();
    tick();
    check("post reset third sample", uo_out, 8'h85);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/tt_um_raybello_tt_pure_sine_gen.md
TT_UM_RAYBELLO_TT_PURE_SINE_GEN -- requirements
Module: tt_um_raybello_tt_pure_sine_gen

Interface
REQ-001 SHALL have one clock and a synchronous, active-low reset: clk and rst_n.
REQ-002 SHALL have port clk, input, 1 bit: sole clock; all state updates on rising edge.
REQ-003 SHALL have port rst_n, input, 1 bit: synchronous active-low reset.
REQ-004 SHALL have port ena, input, 1 bit: design enable; low = all state frozen.
REQ-005 SHALL have port ui_in, input, 8 bits: frequency tuning word FTW (unsigned).
REQ-006 SHALL have port uio_in, input, 8 bits; control inputs:
- [1:0] amplitude shift SH (0..3);
- [2] HOLD;
- [3] FMT (0 = offset-binary, 1 = two's complement);
- [7:4] ignored.
REQ-007 SHALL have port uo_out, output, 8 bits: registered sine sample.
REQ-008 SHALL have port uio_out, output, 8 bits:
- [7] SQ, phase MSB (square wave);
- [6] WRAP pulse;
- [5:0] constant 0.
REQ-009 SHALL have port uio_oe, output, 8 bits: constant 8'hF0.

Function
REQ-010 SHALL keep a 16-bit phase accumulator ACC; each clk with ena=1 and HOLD=0, ACC <= ACC + {8'h00, FTW}, modulo 2^16.
REQ-011 SHALL set WRAP register to 1 for exactly the cycle after an ACC update that carries out of bit 15; otherwise 0, including when frozen.
REQ-012 SHALL derive phase P = ACC[15:8], quadrant QD = P[7:6], index I = P[5:0].
REQ-013 SHALL contain 64-entry quarter-wave ROM Q[i] = round(127*sin(2*pi*(i+0.5)/256)), 7-bit; Q[0]=2, Q[63]=127, monotonic non-decreasing.
REQ-014 SHALL form signed magnitude M per quadrant:
- QD=0: +Q[I];
- QD=1: +Q[63-I];
- QD=2: -Q[I];
- QD=3: -Q[63-I].
M range is -127..+127.
REQ-015 SHALL scale S = M arithmetic-shifted right by SH (rounding toward minus infinity); e.g. -127>>>1 = -64, +127>>>1 = 63.
REQ-016 SHALL output uo_out <= S+128 (8-bit) when FMT=0, or S as two's complement when FMT=1.
REQ-017 SHALL register uo_out, SQ and WRAP, each computed from the current ACC, SH and FMT; uo_out therefore lags ACC by exactly one clock.
REQ-018 SHALL leave ACC, uo_out, SQ and WRAP unchanged when ena=0; ena=1 with HOLD=1 freezes ACC, while uo_out still re-evaluates SH/FMT on the frozen phase.
REQ-019 SHALL apply SH/FMT changes on the next sample without disturbing ACC.
REQ-020 SHALL, with FTW=0, hold ACC constant and give a constant uo_out.
REQ-021 SHALL give an output period of 65536/FTW clocks for FTW that divides 65536 (e.g. FTW=128 gives 512).
REQ-022 SHALL take uo_out, SQ and WRAP only from registers, with no combinational input-to-output paths.

Reset
REQ-023 SHALL, on a clk edge with rst_n=0, set ACC=0, uo_out=8'h80, SQ=0, WRAP=0, regardless of ena, HOLD, FMT or FTW.
REQ-024 SHALL give rst_n priority over every other input; reset asserted mid-period discards the phase immediately.
REQ-025 SHALL, on the first enabled edge after reset release, output the sample for ACC=0: 8'h82 with FMT=0 and SH=0.

Verification
REQ-026 SHALL cover reset: rst_n=0 for 2 clocks, any inputs -> uo_out=0x80, uio_out=0x00, uio_oe=0xF0.
REQ-027 SHALL cover zero frequency: FTW=0, SH=0, FMT=0, ena=1 for 100 clocks -> uo_out constant 0x82, WRAP never 1.
REQ-028 SHALL cover a full period: FTW=128, SH=0, FMT=0 for 1100 clocks -> all of the following:
- max uo_out = 255, min uo_out = 1;
- WRAP pulses exactly every 512 clocks;
- SQ period 512 with 50% duty.
REQ-029 SHALL cover amplitude shift: FTW=128, SH=1 -> max 191, min 64; SH=3 -> max 143, min 112.
REQ-030 SHALL cover two's complement format: FTW=128, FMT=1, SH=0 -> max 0x7F, min 0x81; value 0x02 at phase 0 after reset.
REQ-031 SHALL cover freeze: HOLD=1 (then separately ena=0) for 50 clocks mid-period -> uo_out and SQ unchanged; after release, samples resume from the same phase with no skip.
